// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    START,
    SEND
  } arb_state_t;

  typedef logic [7:0] byte_t;

  localparam int unsigned ARB_MAX_REQ = 8;

  // One-hot decode of a requester index, sized for the largest configuration.
  function automatic logic [ARB_MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [ARB_MAX_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder. Returns the first set
// request at or above ptr, wrapping past N_REQ-1 back to 0.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  // Candidate index with one spare bit so ptr+k can be wrapped by subtraction.
  logic [IDX_W:0] cand;

  // Scan N_REQ candidates starting at ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ valid/ready byte
// sources. Round-robin, packet-granular grants with a per-grant burst limit.
// Optional stall timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > ARB_MAX_REQ) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ must be in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("uart_tx_arbiter: MAX_BURST must be in 1..255");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [7:0]       burst_q;
  logic             last_q;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;

  logic             owner_valid;
  logic             owner_last;
  byte_t            owner_data;

  logic             handshake;
  logic             do_release;
  logic             timeout_hit;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Owner's stream, selected by the one-hot grant register.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[8*i +: 8];
      end
    end
  end

  assign next_ptr = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q;

  // Hit on the TIMEOUT-th consecutive stalled cycle spent in GRANT.
  assign timeout_hit = (state_q == GRANT) && !owner_valid &&
                       (to_cnt_q == TO_W'(TIMEOUT - 1));

  // Count consecutive GRANT cycles in which the owner presents nothing.
  always_ff @(posedge clk) begin
    if (rst || state_q != GRANT || owner_valid) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (handshake) begin
          state_d = START;
        end else if (do_release) begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          state_d = do_release ? IDLE : GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake, ready and release decode from registered state.
  always_comb begin
    req_ready  = '0;
    handshake  = 1'b0;
    do_release = 1'b0;
    case (state_q)
      GRANT: begin
        if (!tx_busy) begin
          req_ready = grant & req_valid;
        end
        handshake  = owner_valid && !tx_busy;
        do_release = timeout_hit;
      end
      SEND: begin
        do_release = !tx_busy && (last_q || burst_q == 8'(MAX_BURST));
      end
      default: begin
      end
    endcase
  end

  // Grant, pointer, burst count and UART byte registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= '0;
      grant_idx <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      ptr_q     <= '0;
      burst_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (state_q == IDLE && pick_found) begin
        grant     <= N_REQ'(idx_to_onehot(3'(pick_idx)));
        grant_idx <= pick_idx;
      end
      if (handshake) begin
        tx_data  <= owner_data;
        tx_start <= 1'b1;
        burst_q  <= burst_q + 8'd1;
        last_q   <= owner_last;
      end
      if (do_release) begin
        ptr_q     <= next_ptr;
        burst_q   <= '0;
        grant     <= '0;
        grant_idx <= '0;
      end
    end
  end

endmodule
